// File: rtl/finder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : finder_pkg
//  Description : Shared types and constants for the finder-pattern sequencer:
//                controller state encoding, read-port owner codes and the
//                stage watchdog counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package finder_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_CROSS = 3'd2,
        ST_DONE  = 3'd3,
        ST_RETRY = 3'd4
    } state_t;

    // Frame-buffer read port owner codes
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_SCAN  = 2'd1;
    localparam logic [1:0] OWN_CROSS = 2'd2;

    // Watchdog counter width (holds values up to 2^20 - 1 with headroom)
    localparam int WD_W = 21;

endpackage : finder_pkg
`default_nettype wire

// File: rtl/stage_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : stage_watchdog
//  Description : Per-stage timeout counter. Counts while enabled, returns to
//                zero on clear, flags expiry on the TIMEOUT_CYCLES-th counted
//                cycle (count == TIMEOUT_CYCLES-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_watchdog
    import finder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WD_W-1:0] c_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] r_count;

    // Cycle counter: clear has priority over counting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_count == c_LAST);

endmodule : stage_watchdog
`default_nettype wire

// File: rtl/finder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : finder_sequencer
//  Description : Top-level controller for finder-pattern location on one
//                captured frame. Sequences capture handoff -> pattern scan ->
//                center search, owns the frame-buffer read port, and retries
//                on later frames up to MAX_RETRIES failed attempts.
//                Optional: define FINDER_WATCHDOG_EN to add a per-stage
//                timeout; otherwise SCAN/CROSS wait indefinitely.
//  Revision    : 1.0 - initial release
// ============================================================================
module finder_sequencer
    import finder_pkg::*;
#(
    parameter int WIDTH          = 480,
    parameter int HEIGHT         = 480,
    parameter int ADDR_W         = 20,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRIES    = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_done,
    input  logic              scan_done,
    input  logic              centers_valid,
    input  logic              centers_not_found_error,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic [ADDR_W-1:0] cross_addr,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [1:0]        rd_owner,
    output logic              scan_start,
    output logic              cross_start,
    output logic              frame_lock,
    output logic              locate_done,
    output logic              locate_fail,
    output logic [1:0]        retry_count,
    output logic              busy
);

    localparam logic [1:0] c_MAX_RETRIES = 2'(MAX_RETRIES);

    state_t     r_state;
    logic [1:0] r_owner;
    logic       r_scan_start;
    logic       r_cross_start;
    logic       r_frame_lock;
    logic       r_locate_done;
    logic       r_locate_fail;
    logic [1:0] r_retry;
    logic       w_expired;

`ifdef FINDER_WATCHDOG_EN
    logic w_wd_enable;
    logic w_wd_clear;

    // Watchdog runs only in the waiting stages and restarts on every exit
    assign w_wd_enable = (r_state == ST_SCAN) || (r_state == ST_CROSS);
    assign w_wd_clear  = !w_wd_enable
                      || ((r_state == ST_SCAN)  && scan_done)
                      || ((r_state == ST_CROSS) && (centers_valid || centers_not_found_error))
                      || w_expired;

    stage_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_stage_watchdog (
        .clk       (clk_in),
        .rst       (rst_in),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // Stage sequencing with registered pulses, lock, owner and retry count
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_NONE;
            r_scan_start  <= 1'b0;
            r_cross_start <= 1'b0;
            r_frame_lock  <= 1'b0;
            r_locate_done <= 1'b0;
            r_locate_fail <= 1'b0;
            r_retry       <= 2'd0;
        end else begin
            r_scan_start  <= 1'b0;
            r_cross_start <= 1'b0;
            r_locate_done <= 1'b0;
            r_locate_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_done) begin
                        r_state      <= ST_SCAN;
                        r_scan_start <= 1'b1;
                        r_frame_lock <= 1'b1;
                        r_owner      <= OWN_SCAN;
                    end
                end
                ST_SCAN: begin
                    // A completed scan beats a coincident timeout
                    if (scan_done) begin
                        r_state       <= ST_CROSS;
                        r_cross_start <= 1'b1;
                        r_owner       <= OWN_CROSS;
                    end else if (w_expired) begin
                        r_state <= ST_RETRY;
                    end
                end
                ST_CROSS: begin
                    // Valid centers win over a same-cycle error or timeout
                    if (centers_valid) begin
                        r_state <= ST_DONE;
                    end else if (centers_not_found_error || w_expired) begin
                        r_state <= ST_RETRY;
                    end
                end
                ST_DONE: begin
                    r_locate_done <= 1'b1;
                    r_retry       <= 2'd0;
                    r_frame_lock  <= 1'b0;
                    r_owner       <= OWN_NONE;
                    r_state       <= ST_IDLE;
                end
                ST_RETRY: begin
                    r_frame_lock <= 1'b0;
                    r_owner      <= OWN_NONE;
                    r_state      <= ST_IDLE;
                    if (r_retry < c_MAX_RETRIES) begin
                        r_retry <= r_retry + 2'd1;
                    end else begin
                        r_locate_fail <= 1'b1;
                        r_retry       <= 2'd0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_owner      <= OWN_NONE;
                    r_frame_lock <= 1'b0;
                end
            endcase
        end
    end

    // Read-port mux keyed off the registered owner, adding no read latency
    always_comb begin
        bram_addr = '0;
        case (r_owner)
            OWN_SCAN:  bram_addr = scan_addr;
            OWN_CROSS: bram_addr = cross_addr;
            default:   bram_addr = '0;
        endcase
    end

    assign rd_owner    = r_owner;
    assign scan_start  = r_scan_start;
    assign cross_start = r_cross_start;
    assign frame_lock  = r_frame_lock;
    assign locate_done = r_locate_done;
    assign locate_fail = r_locate_fail;
    assign retry_count = r_retry;
    assign busy        = (r_state != ST_IDLE);

endmodule : finder_sequencer
`default_nettype wire

// File: tb/tb_finder_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_finder_sequencer
//  Description : Directed self-checking bench for finder_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_finder_sequencer;

    localparam int ADDR_W = 20;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic              frame_done = 1'b0;
    logic              scan_done = 1'b0;
    logic              centers_valid = 1'b0;
    logic              centers_not_found_error = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic [ADDR_W-1:0] cross_addr = '0;
    logic [ADDR_W-1:0] bram_addr;
    logic [1:0]        rd_owner;
    logic              scan_start;
    logic              cross_start;
    logic              frame_lock;
    logic              locate_done;
    logic              locate_fail;
    logic [1:0]        retry_count;
    logic              busy;

    int total = 0;
    int bad   = 0;

    finder_sequencer #(
        .WIDTH          (480),
        .HEIGHT         (480),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRIES    (3)
    ) dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .frame_done              (frame_done),
        .scan_done               (scan_done),
        .centers_valid           (centers_valid),
        .centers_not_found_error (centers_not_found_error),
        .scan_addr               (scan_addr),
        .cross_addr              (cross_addr),
        .bram_addr               (bram_addr),
        .rd_owner                (rd_owner),
        .scan_start              (scan_start),
        .cross_start             (cross_start),
        .frame_lock              (frame_lock),
        .locate_done             (locate_done),
        .locate_fail             (locate_fail),
        .retry_count             (retry_count),
        .busy                    (busy)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are then read 1 time unit after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // From IDLE: start a frame and hand over to the center finder
    task automatic run_to_cross();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        scan_done  = 1'b1;
        tick();
        scan_done  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        total++;
        if ({busy, frame_lock, rd_owner, retry_count, scan_start, cross_start, locate_done, locate_fail} !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b lock=%b own=%0d retry=%0d pulses=%b%b%b%b want all 0",
                     busy, frame_lock, rd_owner, retry_count, scan_start, cross_start, locate_done, locate_fail);
        end
        rst_in = 1'b0;
        tick();
        // scan_done in IDLE must be ignored
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        total++;
        if (busy !== 1'b0 || cross_start !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore_scan_done got busy=%b cross_start=%b want 0 0", busy, cross_start);
        end
    endtask

    task automatic test_happy_path();
        scan_addr  = 20'h01234;
        cross_addr = 20'h0BEEF;
        total++;
        if (bram_addr !== 20'h0) begin
            bad++;
            $display("FAIL mux_idle got %h want 00000", bram_addr);
        end
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (scan_start !== 1'b1 || rd_owner !== 2'd1 || frame_lock !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL scan_entry got start=%b own=%0d lock=%b busy=%b want 1 1 1 1",
                     scan_start, rd_owner, frame_lock, busy);
        end
        total++;
        if (bram_addr !== 20'h01234) begin
            bad++;
            $display("FAIL mux_scan got %h want 01234", bram_addr);
        end
        tick();
        total++;
        if (scan_start !== 1'b0) begin
            bad++;
            $display("FAIL scan_start_width got %b want 0", scan_start);
        end
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        total++;
        if (cross_start !== 1'b1 || rd_owner !== 2'd2 || bram_addr !== 20'h0BEEF) begin
            bad++;
            $display("FAIL cross_entry got start=%b own=%0d addr=%h want 1 2 0beef",
                     cross_start, rd_owner, bram_addr);
        end
        tick();
        total++;
        if (cross_start !== 1'b0 || rd_owner !== 2'd2) begin
            bad++;
            $display("FAIL cross_hold got start=%b own=%0d want 0 2", cross_start, rd_owner);
        end
        centers_valid = 1'b1;
        tick();
        centers_valid = 1'b0;
        total++;
        if (locate_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done_state got done=%b busy=%b want 0 1", locate_done, busy);
        end
        tick();
        total++;
        if (locate_done !== 1'b1 || frame_lock !== 1'b0 || retry_count !== 2'd0 ||
            rd_owner !== 2'd0 || busy !== 1'b0 || bram_addr !== 20'h0) begin
            bad++;
            $display("FAIL locate_done got done=%b lock=%b retry=%0d own=%0d busy=%b addr=%h want 1 0 0 0 0 00000",
                     locate_done, frame_lock, retry_count, rd_owner, busy, bram_addr);
        end
        tick();
        total++;
        if (locate_done !== 1'b0) begin
            bad++;
            $display("FAIL locate_done_width got %b want 0", locate_done);
        end
    endtask

    task automatic test_retry_fail();
        logic [1:0] exp_retry;
        logic       exp_fail;
        for (int i = 1; i <= 4; i++) begin
            run_to_cross();
            centers_not_found_error = 1'b1;
            tick();
            centers_not_found_error = 1'b0;
            tick();
            exp_retry = (i < 4) ? 2'(i) : 2'd0;
            exp_fail  = (i == 4);
            total++;
            if (retry_count !== exp_retry || locate_fail !== exp_fail || frame_lock !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL retry_attempt_%0d got retry=%0d fail=%b lock=%b busy=%b want %0d %b 0 0",
                         i, retry_count, locate_fail, frame_lock, busy, exp_retry, exp_fail);
            end
            tick();
        end
        total++;
        if (locate_fail !== 1'b0) begin
            bad++;
            $display("FAIL locate_fail_width got %b want 0", locate_fail);
        end
    endtask

    task automatic test_simultaneous();
        run_to_cross();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (scan_start !== 1'b0 || rd_owner !== 2'd2) begin
            bad++;
            $display("FAIL frame_done_in_cross got start=%b own=%0d want 0 2", scan_start, rd_owner);
        end
        centers_valid           = 1'b1;
        centers_not_found_error = 1'b1;
        tick();
        centers_valid           = 1'b0;
        centers_not_found_error = 1'b0;
        tick();
        total++;
        if (locate_done !== 1'b1 || locate_fail !== 1'b0 || retry_count !== 2'd0) begin
            bad++;
            $display("FAIL valid_wins got done=%b fail=%b retry=%0d want 1 0 0",
                     locate_done, locate_fail, retry_count);
        end
        tick();
    endtask

    task automatic test_timeout();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
`ifdef FINDER_WATCHDOG_EN
        // Entry edge counts as SCAN cycle 1; expiry at the 16th counted cycle
        for (int k = 0; k < 15; k++) tick();
        total++;
        if (busy !== 1'b1 || rd_owner !== 2'd1 || retry_count !== 2'd0) begin
            bad++;
            $display("FAIL timeout_early got busy=%b own=%0d retry=%0d want 1 1 0", busy, rd_owner, retry_count);
        end
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || retry_count !== 2'd1 || frame_lock !== 1'b0) begin
            bad++;
            $display("FAIL timeout_retry got busy=%b retry=%0d lock=%b want 0 1 0", busy, retry_count, frame_lock);
        end
`else
        for (int k = 0; k < 1000; k++) tick();
        total++;
        if (busy !== 1'b1 || rd_owner !== 2'd1 || retry_count !== 2'd0) begin
            bad++;
            $display("FAIL no_watchdog_hold got busy=%b own=%0d retry=%0d want 1 1 0", busy, rd_owner, retry_count);
        end
        scan_done = 1'b1;
        tick();
        scan_done = 1'b0;
        centers_not_found_error = 1'b1;
        tick();
        centers_not_found_error = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || retry_count !== 2'd1) begin
            bad++;
            $display("FAIL no_watchdog_error got busy=%b retry=%0d want 0 1", busy, retry_count);
        end
`endif
        tick();
    endtask

    task automatic test_async_reset();
        run_to_cross();
        #2;
        rst_in = 1'b1;
        #1;
        total++;
        if ({busy, frame_lock, rd_owner, retry_count, scan_start, cross_start, locate_done, locate_fail} !== 10'd0 ||
            bram_addr !== 20'h0) begin
            bad++;
            $display("FAIL async_reset got busy=%b lock=%b own=%0d retry=%0d addr=%h want all 0",
                     busy, frame_lock, rd_owner, retry_count, bram_addr);
        end
        tick();
        rst_in = 1'b0;
        tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        total++;
        if (scan_start !== 1'b1 || rd_owner !== 2'd1 || frame_lock !== 1'b1 || retry_count !== 2'd0) begin
            bad++;
            $display("FAIL restart_after_reset got start=%b own=%0d lock=%b retry=%0d want 1 1 1 0",
                     scan_start, rd_owner, frame_lock, retry_count);
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_retry_fail();
        test_simultaneous();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_finder_sequencer
`default_nettype wire

// File: doc/finder_sequencer.md
Name: finder_sequencer

Overview:
- Top-level controller for finder-pattern location on one captured frame.
- Sequences three stages: frame capture handoff, horizontal/vertical pattern scan, then cross-pattern center search.
- Owns the single frame-buffer read port and muxes it to whichever stage is active.
- Handles stage failure and timeout with bounded retries on later frames; reports success or final failure.

Parameters:
WIDTH, 480, frame width in pixels
HEIGHT, 480, frame height in pixels
ADDR_W, 20, frame-buffer address width
TIMEOUT_CYCLES, 1048576, per-stage watchdog limit in clk_in cycles (counter is 21 bits)
MAX_RETRIES, 3, failed attempts allowed before locate_fail (retry_count is 2 bits)

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
frame_done  input  1  one-cycle pulse: new frame fully written to buffer
scan_done  input  1  one-cycle pulse: pattern scanners finished, horz/vert vectors stable
centers_valid  input  1  one-cycle pulse from center finder: three centers available
centers_not_found_error  input  1  level/pulse from center finder: search exhausted
scan_addr  input  ADDR_W  read address requested by scanners
cross_addr  input  ADDR_W  read address requested by center finder
bram_addr  output  ADDR_W  frame-buffer read address
rd_owner  output  2  0 none, 1 scanner, 2 center finder
scan_start  output  1  one-cycle pulse: start pattern scan
cross_start  output  1  one-cycle pulse: start center search
frame_lock  output  1  high = camera writer must not overwrite buffer
locate_done  output  1  one-cycle pulse: centers valid this attempt
locate_fail  output  1  one-cycle pulse: retries exhausted
retry_count  output  2  failed attempts so far on current locate
busy  output  1  high in any state but IDLE

Behaviour:
- Async reset: state IDLE; all pulses 0, frame_lock 0, rd_owner 0, retry_count 0, watchdog 0, busy 0.
- bram_addr is combinational from rd_owner (scan_addr / cross_addr / 0), so requester read latency is unchanged (2 cycles).
- rd_owner is registered with state.
- IDLE:
  - frame_done → SCAN next cycle.
  - In the same transition: scan_start=1 for one cycle, frame_lock=1, rd_owner=1, watchdog cleared.
- SCAN:
  - scan_done → CROSS.
  - In the same transition: cross_start=1 for one cycle, rd_owner=2, watchdog cleared.
- CROSS:
  - centers_valid → DONE.
  - centers_not_found_error or watchdog expiry → RETRY.
  - centers_valid and error in the same cycle: valid wins.
- SCAN watchdog expiry → RETRY.
- DONE (one cycle): locate_done=1, retry_count←0, frame_lock←0, rd_owner←0, → IDLE.
- RETRY (one cycle): frame_lock←0, rd_owner←0.
  - If retry_count < MAX_RETRIES: retry_count+1, → IDLE to await the next frame.
  - Otherwise: locate_fail=1, retry_count←0, → IDLE.
- Watchdog: increments each cycle in SCAN/CROSS and clears on every state change. Expiry is count == TIMEOUT_CYCLES-1.
- frame_done outside IDLE is ignored (frame locked); it is not queued.
- scan_done outside SCAN and centers_* outside CROSS are ignored.
- Reset mid-operation: immediate return to IDLE, lock released, no pulses emitted.

Optional Feature:
- Macro FINDER_WATCHDOG_EN.
- Defined: watchdog behaves as above.
- Undefined: no watchdog counter is synthesized; SCAN/CROSS wait indefinitely and only centers_not_found_error leads to RETRY.

Decomposition:
- finder_pkg holds:
  - state enum {IDLE, SCAN, CROSS, DONE, RETRY}
  - owner codes OWN_NONE=0, OWN_SCAN=1, OWN_CROSS=2
  - watchdog width constant
- One sub-module, stage_watchdog: clear/enable inputs, expired output, parameter TIMEOUT_CYCLES. It is instantiated only under FINDER_WATCHDOG_EN.

Test Plan:
- Happy path: frame_done@t0 → scan_start@t1, rd_owner=1; scan_done → cross_start next cycle, rd_owner=2; centers_valid → locate_done one cycle later, frame_lock=0, retry_count=0.
- Mux: in SCAN with scan_addr=0x1234, cross_addr=0x0BEEF → bram_addr=0x1234; in CROSS → bram_addr=0x0BEEF; in IDLE → bram_addr=0.
- Retry/fail: four consecutive attempts each ending in centers_not_found_error → retry_count 1, 2, 3; locate_fail pulses on the 4th attempt; retry_count returns to 0.
- Timeout (FINDER_WATCHDOG_EN, TIMEOUT_CYCLES=16): no scan_done after scan_start → RETRY after exactly 16 SCAN cycles, retry_count=1; without the macro, state stays SCAN for 1000 cycles.
- Simultaneous/ignored events: centers_valid and error in the same cycle → locate_done, retry_count unchanged; frame_done during CROSS → no new scan_start.
- Async reset asserted mid-CROSS between clock edges → outputs zero immediately; frame_done after release starts a fresh scan.
